// File: rtl/mem_bank_pwr_seq.sv
// Power sequencer for NB_BANKS SRAM banks: steps retention entry/exit one bank at a time,
// spacing each pin change by delay_i ticks of the 32 kHz clock.
module mem_bank_pwr_seq #(
  parameter int unsigned NB_BANKS = 4,
  parameter int unsigned DELAY_W  = 8,
  localparam int unsigned IdxW    = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                clk32_i,
  input  logic                pwr_req_i,
  input  logic [NB_BANKS-1:0] bank_keep_i,
  input  logic [DELAY_W-1:0]  delay_i,
  output logic                pwr_ack_o,
  output logic                busy_o,
  output logic [NB_BANKS-1:0] mem_sleep_o,
  output logic [NB_BANKS-1:0] mem_gate_o,
  output logic [IdxW-1:0]     bank_idx_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB_BANKS - 1);

  typedef enum logic [2:0] {
    StIdle, StDnSleep, StDnGate, StRet, StUpUngate, StUpWake
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DELAY_W-1:0]  cnt_q, cnt_d;
  logic [NB_BANKS-1:0] sleep_q, sleep_d;
  logic [NB_BANKS-1:0] gate_q, gate_d;
  logic                skip_q, skip_d;
  logic                abort_q, abort_d;
  logic [2:0]          sync_q;
  logic                tick, done, abort, step;

  assign tick  = sync_q[1] & ~sync_q[2];
  // A skipped step lasts exactly one cycle regardless of delay_i.
  assign done  = skip_q | (cnt_q == delay_i);
  assign abort = abort_q | ~pwr_req_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sleep_d = sleep_q;
    gate_d  = gate_q;
    skip_d  = skip_q;
    abort_d = abort_q;
    cnt_d   = cnt_q + DELAY_W'(tick);
    step    = 1'b0;

    if ((state_q == StDnSleep || state_q == StDnGate) && !pwr_req_i) abort_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (pwr_req_i) begin
          state_d = StDnSleep;
          idx_d   = '0;
          step    = 1'b1;
        end
      end
      StDnSleep: begin
        if (done) begin
          step = 1'b1;
          if (abort) begin
            state_d = StUpUngate;
          end else if (!skip_q) begin
            state_d = StDnGate;
          end else if (idx_q == LastIdx) begin
            state_d = StRet;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDnGate: begin
        if (done) begin
          step = 1'b1;
          if (abort) begin
            state_d = StUpUngate;
          end else if (idx_q == LastIdx) begin
            state_d = StRet;
          end else begin
            state_d = StDnSleep;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StRet: begin
        if (!pwr_req_i) begin
          state_d = StUpUngate;
          idx_d   = LastIdx;
          step    = 1'b1;
        end
      end
      StUpUngate: begin
        if (done) begin
          state_d = StUpWake;
          step    = 1'b1;
        end
      end
      StUpWake: begin
        if (done) begin
          step = 1'b1;
          if (idx_q == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StUpUngate;
            idx_d   = idx_q - IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin changes happen on the edge that enters a step, so its WAIT starts at once.
    if (step) begin
      cnt_d   = '0;
      skip_d  = 1'b0;
      abort_d = 1'b0;
      unique case (state_d)
        StDnSleep: begin
          if (bank_keep_i[idx_d]) skip_d = 1'b1;
          else                    sleep_d[idx_d] = 1'b1;
        end
        StDnGate:  gate_d[idx_d] = 1'b1;
        StUpUngate: begin
          if (!gate_q[idx_d]) skip_d = 1'b1;
          else                gate_d[idx_d] = 1'b0;
        end
        StUpWake:  sleep_d[idx_d] = 1'b0;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      sleep_q <= '0;
      gate_q  <= '0;
      skip_q  <= 1'b0;
      abort_q <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sleep_q <= sleep_d;
      gate_q  <= gate_d;
      skip_q  <= skip_d;
      abort_q <= abort_d;
      sync_q  <= {sync_q[1:0], clk32_i};
    end
  end

  assign pwr_ack_o   = (state_q == StRet);
  assign busy_o      = (state_q != StIdle) && (state_q != StRet);
  assign mem_sleep_o = sleep_q;
  assign mem_gate_o  = gate_q;
  assign bank_idx_o  = idx_q;

  // A gated bank that is not in retention would lose its contents.
  assert property (@(posedge HCLK) disable iff (HRESET) (gate_q & ~sleep_q) == '0);

endmodule

// File: tb/tb_mem_bank_pwr_seq.sv
// Bench for mem_bank_pwr_seq: per-cycle vector table at delay 0, plus tick-paced,
// request-during-power-up and reset-in-retention sequences.
module tb_mem_bank_pwr_seq;

  typedef struct {
    logic       req;
    logic [3:0] keep;
    logic [3:0] sleep;
    logic [3:0] gate;
    logic       ack;
    logic       busy;
    logic [1:0] idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk32 = 1'b0;
  logic       req = 1'b0;
  logic [3:0] keep = '0;
  logic [7:0] delay = 8'd2;
  logic       ack, busy;
  logic [3:0] sleep, gate;
  logic [1:0] idx;
  bit         clk32_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs[$];

  mem_bank_pwr_seq #(.NB_BANKS(4), .DELAY_W(8)) dut (
    .HCLK       (clk),
    .HRESET     (rst),
    .clk32_i    (clk32),
    .pwr_req_i  (req),
    .bank_keep_i(keep),
    .delay_i    (delay),
    .pwr_ack_o  (ack),
    .busy_o     (busy),
    .mem_sleep_o(sleep),
    .mem_gate_o (gate),
    .bank_idx_o (idx)
  );

  always #5 clk = ~clk;

  // clk32 stand-in: one rising edge every 16 HCLK cycles, kept clear of the HCLK edge.
  always begin
    repeat (8) @(posedge clk);
    #2;
    if (clk32_en) clk32 = ~clk32;
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((gate & ~sleep) != 4'b0) begin
        errors++;
        $display("FAIL invariant gate=%b sleep=%b", gate, sleep);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] k, input logic [3:0] s, input logic [3:0] g,
                     input logic a, input logic b, input logic [1:0] i);
    vec_t v;
    v.req = r; v.keep = k; v.sleep = s; v.gate = g; v.ack = a; v.busy = b; v.idx = i;
    vecs.push_back(v);
  endtask

  task automatic tick1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pins(input string name, input logic [3:0] s, input logic [3:0] g,
                            input logic a, input logic b);
    check({name, " sleep"}, 32'(sleep), 32'(s));
    check({name, " gate"}, 32'(gate), 32'(g));
    check({name, " ack"}, 32'(ack), 32'(a));
    check({name, " busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    int n;

    // Full power-down / power-up, delay 0: one step per HCLK.
    add(1, 4'h0, 4'b0001, 4'b0000, 0, 1, 0);
    add(1, 4'h0, 4'b0001, 4'b0001, 0, 1, 0);
    add(1, 4'h0, 4'b0011, 4'b0001, 0, 1, 1);
    add(1, 4'h0, 4'b0011, 4'b0011, 0, 1, 1);
    add(1, 4'h0, 4'b0111, 4'b0011, 0, 1, 2);
    add(1, 4'h0, 4'b0111, 4'b0111, 0, 1, 2);
    add(1, 4'h0, 4'b1111, 4'b0111, 0, 1, 3);
    add(1, 4'h0, 4'b1111, 4'b1111, 0, 1, 3);
    add(1, 4'h0, 4'b1111, 4'b1111, 1, 0, 3);
    add(1, 4'h0, 4'b1111, 4'b1111, 1, 0, 3);
    add(0, 4'h0, 4'b1111, 4'b0111, 0, 1, 3);
    add(0, 4'h0, 4'b0111, 4'b0111, 0, 1, 3);
    add(0, 4'h0, 4'b0111, 4'b0011, 0, 1, 2);
    add(0, 4'h0, 4'b0011, 4'b0011, 0, 1, 2);
    add(0, 4'h0, 4'b0011, 4'b0001, 0, 1, 1);
    add(0, 4'h0, 4'b0001, 4'b0001, 0, 1, 1);
    add(0, 4'h0, 4'b0001, 4'b0000, 0, 1, 0);
    add(0, 4'h0, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0);
    // Banks 0 and 2 kept.
    add(1, 4'b0101, 4'b0000, 4'b0000, 0, 1, 0);
    add(1, 4'b0101, 4'b0010, 4'b0000, 0, 1, 1);
    add(1, 4'b0101, 4'b0010, 4'b0010, 0, 1, 1);
    add(1, 4'b0101, 4'b0010, 4'b0010, 0, 1, 2);
    add(1, 4'b0101, 4'b1010, 4'b0010, 0, 1, 3);
    add(1, 4'b0101, 4'b1010, 4'b1010, 0, 1, 3);
    add(1, 4'b0101, 4'b1010, 4'b1010, 1, 0, 3);
    add(0, 4'b0101, 4'b1010, 4'b0010, 0, 1, 3);
    add(0, 4'b0101, 4'b0010, 4'b0010, 0, 1, 3);
    add(0, 4'b0101, 4'b0010, 4'b0010, 0, 1, 2);
    add(0, 4'b0101, 4'b0010, 4'b0010, 0, 1, 2);
    add(0, 4'b0101, 4'b0010, 4'b0000, 0, 1, 1);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 1, 1);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0);
    // Abort while gating bank 1: power-up from bank 1, banks 2/3 untouched.
    add(1, 4'h0, 4'b0001, 4'b0000, 0, 1, 0);
    add(1, 4'h0, 4'b0001, 4'b0001, 0, 1, 0);
    add(1, 4'h0, 4'b0011, 4'b0001, 0, 1, 1);
    add(1, 4'h0, 4'b0011, 4'b0011, 0, 1, 1);
    add(0, 4'h0, 4'b0011, 4'b0001, 0, 1, 1);
    add(0, 4'h0, 4'b0001, 4'b0001, 0, 1, 1);
    add(0, 4'h0, 4'b0001, 4'b0000, 0, 1, 0);
    add(0, 4'h0, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_pins("reset", 4'b0, 4'b0, 1'b0, 1'b0);
    check("reset idx", 32'(idx), 32'd0);
    rst   = 1'b0;
    delay = 8'd0;

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      keep = vecs[i].keep;
      tick1();
      check_pins($sformatf("vec%0d", i), vecs[i].sleep, vecs[i].gate, vecs[i].ack, vecs[i].busy);
      check($sformatf("vec%0d idx", i), 32'(idx), 32'(vecs[i].idx));
    end

    // Request re-raised during power-up is ignored until IDLE, then restarts.
    req  = 1'b1;
    keep = '0;
    repeat (9) tick1();
    check_pins("reraise ret", 4'b1111, 4'b1111, 1'b1, 1'b0);
    req = 1'b0;
    tick1();
    req = 1'b1;
    repeat (8) tick1();
    check_pins("reraise idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick1();
    check_pins("reraise restart", 4'b0001, 4'b0000, 1'b0, 1'b1);

    // Reset while in retention with every pin set.
    repeat (8) tick1();
    check_pins("rst_ret before", 4'b1111, 4'b1111, 1'b1, 1'b0);
    rst = 1'b1;
    tick1();
    check_pins("rst_ret after", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    req = 1'b0;
    tick1();

    // Tick-paced sequence, delay 2, clk32 rising every 16 HCLK.
    delay    = 8'd2;
    clk32_en = 1'b1;
    req      = 1'b1;
    tick1();
    check_pins("t2 first", 4'b0001, 4'b0000, 1'b0, 1'b1);
    n = 0;
    while (gate[0] !== 1'b1 && n < 100) begin
      tick1();
      n++;
    end
    check("t2 gate0 set", 32'(gate[0]), 32'd1);
    check("t2 gate0 spacing in 17..40", 32'(n >= 17 && n <= 40), 32'd1);
    n = 0;
    while (ack !== 1'b1 && n < 1000) begin
      tick1();
      n++;
    end
    check_pins("t2 ret", 4'b1111, 4'b1111, 1'b1, 1'b0);
    req = 1'b0;
    tick1();
    check_pins("t2 ungate3", 4'b1111, 4'b0111, 1'b0, 1'b1);
    n = 0;
    while (gate !== 4'b0000 && n < 1000) begin
      tick1();
      n++;
    end
    check("t2 last gate cleared", 32'(gate), 32'd0);
    check("t2 sleep0 last", 32'(sleep), 32'b0001);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick1();
      n++;
    end
    check_pins("t2 idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
